exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 145 ++++++++++++++
 tb/tb_exec_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Multi-cycle execution unit: registered ALU with a valid/ready handshake and an
// iterative one-bit-per-cycle shifter. Defining BARREL_SHIFT_EN makes every shift single-cycle.
module exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic        illegal_q, illegal_d;
    logic [31:0] alu_res;
    logic        alu_ill;
    logic [4:0]  shamt;

    assign shamt = op_b[4:0];

`ifndef BARREL_SHIFT_EN
    // Working shift state: remaining count and direction/fill of the pending shift.
    logic [4:0] cnt_q, cnt_d;
    logic       shl_q, shl_d;
    logic       arith_q, arith_d;
    logic       is_shift;

    assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
`endif

    always_comb begin
        alu_res = 32'd0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {31'd0, op_a < op_b};
`ifdef BARREL_SHIFT_EN
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
`else
            // Iterative build: this is the shamt=0 answer and the shifter's seed value.
            OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifndef BARREL_SHIFT_EN
        cnt_d     = cnt_q;
        shl_d     = shl_q;
        arith_d   = arith_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    result_d  = alu_res;
                    illegal_d = alu_ill;
                    state_d   = DONE;
`ifndef BARREL_SHIFT_EN
                    if (is_shift && (shamt != 5'd0)) begin
                        cnt_d   = shamt;
                        shl_d   = (alu_ctrl == OP_SLL);
                        arith_d = (alu_ctrl == OP_SRA);
                        state_d = SHIFT;
                    end
`endif
                end
            end
`ifdef BARREL_SHIFT_EN
            SHIFT: state_d = IDLE;
`else
            SHIFT: begin
                if (shl_q) result_d = {result_q[30:0], 1'b0};
                else       result_d = {arith_q & result_q[31], result_q[31:1]};
                cnt_d = cnt_q - 5'd1;
                // Leave on the step that takes the counter to zero: latency shamt+1.
                if (cnt_q == 5'd1) state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= 32'd0;
            illegal_q <= 1'b0;
`ifndef BARREL_SHIFT_EN
            cnt_q     <= 5'd0;
            shl_q     <= 1'b0;
            arith_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifndef BARREL_SHIFT_EN
            cnt_q     <= cnt_d;
            shl_q     <= shl_d;
            arith_q   <= arith_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign illegal   = illegal_q;
    // Qualified by DONE so zero reads 0 in reset and while a shift is in flight.
    assign zero      = out_valid && (result_q == 32'd0);

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: ALU vectors, shift latency,
// output hold under back-pressure and reset abort mid-shift.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int failures = 0;

`ifdef BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    exec_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int shift_lat(input logic [31:0] b);
        if (BARREL || (b[4:0] == 5'd0)) return 1;
        return int'(b[4:0]) + 1;
    endfunction

    // Offer one op in IDLE, then scramble the inputs right after the accepting edge.
    task automatic start_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = ~c;
        op_a     = ~a;
        op_b     = ~b;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
        start_op(tag, c, a, b);
        wait_done(tag, exp_lat);
        chk({tag, "_result"},  result, exp_res);
        chk({tag, "_zero"},    32'(zero), 32'(exp_res == 32'd0));
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        release_result(tag);
    endtask

    initial begin
        bit saw_valid;

        repeat (2) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    result, 32'd0);
        chk("rst_zero",      32'(zero), 32'd0);
        chk("rst_illegal",   32'(illegal), 32'd0);
        rst_n = 1'b1;

        run_op("and",    4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1);
        run_op("or",     4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1);
        run_op("add_wr", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
        run_op("sub",    4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
        run_op("xor",    4'b0111, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1);
        run_op("slt_m1", 4'b0100, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1);
        run_op("sltu_m1",4'b0101, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1);
        run_op("slt_p1", 4'b0100, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1);
        run_op("sltu_p1",4'b0101, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1);
        run_op("sll4",   4'b0011, 32'd1,         32'h0000_0104, 32'h0000_0010, 1'b0, shift_lat(32'h0000_0104));
        run_op("sll1",   4'b0011, 32'h8000_0001, 32'd1,         32'h0000_0002, 1'b0, shift_lat(32'd1));
        run_op("srl4",   4'b1000, 32'h0000_00F0, 32'd4,         32'h0000_000F, 1'b0, shift_lat(32'd4));
        run_op("srl31",  4'b1000, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, shift_lat(32'd31));
        run_op("sra31",  4'b1010, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, shift_lat(32'd31));
        run_op("sra8",   4'b1010, 32'h7FFF_0000, 32'd8,         32'h007F_FF00, 1'b0, shift_lat(32'd8));
        run_op("sra0",   4'b1010, 32'hF000_0000, 32'h0000_0020, 32'hF000_0000, 1'b0, 1);
        run_op("ill_f",  4'b1111, 32'h0000_1234, 32'h0000_5678, 32'd0,         1'b1, 1);
        run_op("ill_9",  4'b1001, 32'hFFFF_FFFF, 32'd3,         32'd0,         1'b1, 1);

        // Back-pressure: result held for 5 cycles while another op is offered.
        start_op("hold", 4'b0010, 32'd3, 32'd4);
        wait_done("hold", 1);
        in_valid = 1'b1;
        alu_ctrl = 4'b0110;
        op_a     = 32'd100;
        op_b     = 32'd1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_result",   result, 32'd7);
            chk("hold_illegal",  32'(illegal), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_result("hold");
        chk("hold_idle_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of a 10-step shift kills it outright.
        start_op("abort", 4'b0011, 32'd1, 32'd10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid",    32'(out_valid), 32'd0);
        chk("abort_result",   result, 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_stale", 32'(saw_valid), 32'd0);
        chk("abort_ready",    32'(in_ready), 32'd1);
        run_op("post_rst", 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
